pipe_stage_reg: RTL and testbench

- Parametrised successor to the fixed EX/MEM pipeline register: one generic inter-stage register usable for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Adds a valid/ready handshake (stall), synchronous flush (bubble insertion), and forced-zero control bits on bubbles.
- Adds an optional 2-entry skid mode that removes the combinational ready path and keeps full throughput.
- Adds a saturating bubble counter for CPI measurement.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_stage_reg.sv | 185 ++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the generic inter-stage pipeline register.
package pipe_pkg;

  localparam int RN_W      = 5;
  localparam int WORD_W    = 32;
  localparam int EM_CTRL_W = 3;

  // Bit positions of the EX/MEM control bits inside ctrl.
  localparam int CTRL_WREG  = 2;
  localparam int CTRL_M2REG = 1;
  localparam int CTRL_WMEM  = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register with flush, bubble masking,
// optional 2-entry skid buffer and a saturating bubble counter.
//
// state    | meaning (SKID=1 only)
// ---------+-------------------------------------------
// ST_EMPTY | nothing held, out_valid=0
// ST_ONE   | main holds the head entry, in_ready=1
// ST_TWO   | main holds head, skid holds next, in_ready=0
module pipe_stage_reg #(
  parameter int CTRL_W = pipe_pkg::EM_CTRL_W,
  parameter int RN_W   = pipe_pkg::RN_W,
  parameter int DATA_W = 2 * pipe_pkg::WORD_W,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [RN_W-1:0]   in_rn,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RN_W-1:0]   out_rn,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt
);
  import pipe_pkg::*;

  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [RN_W-1:0]   rn_q, rn_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  generate
    if (SKID == 0) begin : gen_single
      assign in_ready = !out_valid_q || out_ready;

      // Single register: load on input transfer, drain on output transfer.
      always_comb begin
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        rn_d        = rn_q;
        data_d      = data_q;
        if (flush) begin
          out_valid_d = 1'b0;
        end else if (in_xfer) begin
          out_valid_d = 1'b1;
          ctrl_d      = in_ctrl;
          rn_d        = in_rn;
          data_d      = in_data;
        end else if (out_xfer) begin
          out_valid_d = 1'b0;
        end
      end
    end else begin : gen_skid
      skid_state_e       state_q, state_d;
      logic              in_ready_q, in_ready_d;
      logic [CTRL_W-1:0] sk_ctrl_q, sk_ctrl_d;
      logic [RN_W-1:0]   sk_rn_q, sk_rn_d;
      logic [DATA_W-1:0] sk_data_q, sk_data_d;

      assign in_ready = in_ready_q;

      // Skid FSM: the second entry absorbs the input that arrives while
      // downstream stalls, so in_ready never depends on out_ready.
      always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        rn_d      = rn_q;
        data_d    = data_q;
        sk_ctrl_d = sk_ctrl_q;
        sk_rn_d   = sk_rn_q;
        sk_data_d = sk_data_q;
        if (flush) begin
          state_d   = ST_EMPTY;
          sk_ctrl_d = '0;
          sk_rn_d   = '0;
          sk_data_d = '0;
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (in_xfer) begin
                ctrl_d  = in_ctrl;
                rn_d    = in_rn;
                data_d  = in_data;
                state_d = ST_ONE;
              end
            end
            ST_ONE: begin
              if (in_xfer && out_ready) begin
                ctrl_d = in_ctrl;
                rn_d   = in_rn;
                data_d = in_data;
              end else if (in_xfer) begin
                sk_ctrl_d = in_ctrl;
                sk_rn_d   = in_rn;
                sk_data_d = in_data;
                state_d   = ST_TWO;
              end else if (out_ready) begin
                state_d = ST_EMPTY;
              end
            end
            ST_TWO: begin
              if (out_ready) begin
                ctrl_d  = sk_ctrl_q;
                rn_d    = sk_rn_q;
                data_d  = sk_data_q;
                state_d = ST_ONE;
              end
            end
            default: state_d = ST_EMPTY;
          endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
      end

      // Skid state, registered ready and second entry.
      always_ff @(posedge clk) begin
        if (reset) begin
          state_q    <= ST_EMPTY;
          in_ready_q <= 1'b1;
          sk_ctrl_q  <= '0;
          sk_rn_q    <= '0;
          sk_data_q  <= '0;
        end else begin
          state_q    <= state_d;
          in_ready_q <= in_ready_d;
          sk_ctrl_q  <= sk_ctrl_d;
          sk_rn_q    <= sk_rn_d;
          sk_data_q  <= sk_data_d;
        end
      end
    end
  endgenerate

  // Main output register shared by both modes.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      rn_q        <= '0;
      data_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      rn_q        <= rn_d;
      data_q      <= data_d;
    end
  end

  // Bubble counter: counts idle output cycles, sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (!out_valid_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Bubble counter register; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_ctrl   = ctrl_q & {CTRL_W{out_valid_q}};
  assign out_rn     = rn_q;
  assign out_data   = data_q;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: instance a is the plain register,
// instance b is the skid variant with a 4-bit bubble counter.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [4:0]  rn;
    logic [63:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [2:0]  a_in_ctrl, a_out_ctrl;
  logic [4:0]  a_in_rn, a_out_rn;
  logic [63:0] a_in_data, a_out_data;
  logic [15:0] a_cnt;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [2:0]  b_in_ctrl, b_out_ctrl;
  logic [4:0]  b_in_rn, b_out_rn;
  logic [63:0] b_in_data, b_out_data;
  logic [3:0]  b_cnt;

  ent_t q0[$];
  ent_t q1[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [15:0] cnt_ref;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(3), .RN_W(5), .DATA_W(64), .SKID(0), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ctrl(a_in_ctrl), .in_rn(a_in_rn), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_ctrl(a_out_ctrl), .out_rn(a_out_rn), .out_data(a_out_data),
    .bubble_cnt(a_cnt));

  pipe_stage_reg #(.CTRL_W(3), .RN_W(5), .DATA_W(64), .SKID(1), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ctrl(b_in_ctrl), .in_rn(b_in_rn), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_ctrl(b_out_ctrl), .out_rn(b_out_rn), .out_data(b_out_data),
    .bubble_cnt(b_cnt));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard step at the falling edge, then advance past the next rising edge.
  task automatic tick();
    ent_t e;
    @(negedge clk);
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      if (a_out_valid === 1'b0) check("a_bubble_mask", 64'(a_out_ctrl), 64'd0);
      if (a_out_valid === 1'b1 && a_out_ready) begin
        n_tests++;
        assert (q0.size() != 0) else begin
          n_fail++;
          $error("FAIL a_spurious: observed data 0x%0h expected no output", a_out_data);
        end
        if (q0.size() != 0) begin
          e = q0.pop_front();
          check("a_data", a_out_data, e.data);
          check("a_ctrl", 64'(a_out_ctrl), 64'(e.ctrl));
          check("a_rn", 64'(a_out_rn), 64'(e.rn));
        end
      end
      if (a_flush) q0.delete();
      else if (a_in_valid && a_in_ready === 1'b1) q0.push_back('{a_in_ctrl, a_in_rn, a_in_data});

      if (b_out_valid === 1'b0) check("b_bubble_mask", 64'(b_out_ctrl), 64'd0);
      if (b_out_valid === 1'b1 && b_out_ready) begin
        n_tests++;
        assert (q1.size() != 0) else begin
          n_fail++;
          $error("FAIL b_spurious: observed data 0x%0h expected no output", b_out_data);
        end
        if (q1.size() != 0) begin
          e = q1.pop_front();
          check("b_data", b_out_data, e.data);
          check("b_ctrl", 64'(b_out_ctrl), 64'(e.ctrl));
          check("b_rn", 64'(b_out_rn), 64'(e.rn));
        end
      end
      if (b_flush) q1.delete();
      else if (b_in_valid && b_in_ready === 1'b1) q1.push_back('{b_in_ctrl, b_in_rn, b_in_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [63:0] d);
    a_in_valid = v;
    a_in_data  = d;
    a_in_ctrl  = d[2:0];
    a_in_rn    = d[4:0] ^ 5'h15;
  endtask

  task automatic drive_b(input logic v, input logic [63:0] d);
    b_in_valid = v;
    b_in_data  = d;
    b_in_ctrl  = d[2:0];
    b_in_rn    = d[4:0] ^ 5'h0a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    a_flush = 1'b0; a_out_ready = 1'b1;
    b_flush = 1'b0; b_out_ready = 1'b1;
    drive_a(1'b1, 64'h7); a_in_ctrl = 3'b111;
    drive_b(1'b1, 64'h7); b_in_ctrl = 3'b111;
    tick();
    tick();
    reset = 1'b0;
    drive_a(1'b0, 64'h0);
    drive_b(1'b0, 64'h0);
    check("rst_a_valid", 64'(a_out_valid), 64'd0);
    check("rst_a_ctrl", 64'(a_out_ctrl), 64'd0);
    check("rst_a_cnt", 64'(a_cnt), 64'd0);
    check("rst_b_valid", 64'(b_out_valid), 64'd0);
    check("rst_b_ctrl", 64'(b_out_ctrl), 64'd0);
    check("rst_b_cnt", 64'(b_cnt), 64'd0);
    check("rst_a_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_b_in_ready", 64'(b_in_ready), 64'd1);

    // Saturation of the 4-bit counter on an idle stage.
    for (int i = 0; i < 14; i++) tick();
    check("sat_b_14", 64'(b_cnt), 64'd14);
    tick();
    check("sat_b_15", 64'(b_cnt), 64'd15);
    for (int i = 0; i < 3; i++) tick();
    check("sat_b_hold", 64'(b_cnt), 64'd15);
    check("a_cnt_18", 64'(a_cnt), 64'd18);

    // Streaming through the plain register: one bubble at the start only.
    cnt_ref = a_cnt;
    for (int i = 1; i <= 8; i++) begin
      drive_a(1'b1, 64'(i));
      tick();
      check("a_stream_valid", 64'(a_out_valid), 64'd1);
    end
    drive_a(1'b0, 64'h0);
    tick();
    check("a_stream_cnt", 64'(a_cnt), 64'(cnt_ref + 16'd1));
    check("a_stream_drain", 64'(q0.size()), 64'd0);

    // Bubble masking with control bits stuck high on the input.
    cnt_ref = a_cnt;
    a_in_ctrl = 3'((1 << CTRL_WREG) | (1 << CTRL_WMEM));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("a_mask_ctrl", 64'(a_out_ctrl), 64'd0);
    end
    check("a_cnt_plus5", 64'(a_cnt), 64'(cnt_ref + 16'd5));

    // Flush on the plain register: output transfer counts, input is discarded.
    a_out_ready = 1'b0;
    drive_a(1'b1, 64'h11);
    tick();
    check("a_stall_ready", 64'(a_in_ready), 64'd0);
    a_out_ready = 1'b1;
    drive_a(1'b1, 64'h66);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    drive_a(1'b0, 64'h0);
    check("a_flush_valid", 64'(a_out_valid), 64'd0);
    check("a_flush_ready", 64'(a_in_ready), 64'd1);
    for (int i = 0; i < 3; i++) tick();

    // Streaming through the skid variant.
    for (int i = 1; i <= 8; i++) begin
      drive_b(1'b1, 64'(i));
      tick();
      check("b_stream_valid", 64'(b_out_valid), 64'd1);
      check("b_stream_ready", 64'(b_in_ready), 64'd1);
    end
    drive_b(1'b0, 64'h0);
    tick();
    check("b_stream_drain", 64'(q1.size()), 64'd0);

    // Backpressure: A, B, C with out_ready low for three cycles.
    drive_b(1'b1, 64'hA1);
    tick();
    check("bp_a_appears", b_out_data, 64'hA1);
    drive_b(1'b1, 64'hB2);
    b_out_ready = 1'b0;
    tick();
    check("bp_ready_fall", 64'(b_in_ready), 64'd0);
    check("bp_hold_a0", b_out_data, 64'hA1);
    drive_b(1'b1, 64'hC3);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bp_ready_low", 64'(b_in_ready), 64'd0);
      check("bp_hold_a", b_out_data, 64'hA1);
      check("bp_hold_ctrl", 64'(b_out_ctrl), 64'h1);
    end
    b_out_ready = 1'b1;
    tick();
    check("bp_b_head", b_out_data, 64'hB2);
    tick();
    check("bp_c_head", b_out_data, 64'hC3);
    drive_b(1'b0, 64'h0);
    tick();
    check("bp_drain", 64'(q1.size()), 64'd0);
    check("bp_empty", 64'(b_out_valid), 64'd0);

    // Flush with the skid full and a pending input 0x55.
    b_out_ready = 1'b0;
    drive_b(1'b1, 64'h21);
    tick();
    drive_b(1'b1, 64'h32);
    tick();
    check("fl_two_ready", 64'(b_in_ready), 64'd0);
    drive_b(1'b1, 64'h55);
    b_flush = 1'b1;
    tick();
    b_flush = 1'b0;
    drive_b(1'b0, 64'h0);
    check("fl_valid", 64'(b_out_valid), 64'd0);
    check("fl_ctrl", 64'(b_out_ctrl), 64'd0);
    check("fl_ready", 64'(b_in_ready), 64'd1);
    b_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_stay_empty", 64'(b_out_valid), 64'd0);
    end

    // Reset in the middle of a stall drops the held entry.
    a_out_ready = 1'b0;
    drive_a(1'b1, 64'h99);
    tick();
    drive_a(1'b0, 64'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_out_ready = 1'b1;
    check("mid_rst_valid", 64'(a_out_valid), 64'd0);
    check("mid_rst_data", a_out_data, 64'd0);
    check("mid_rst_cnt", 64'(a_cnt), 64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
